// File: rtl/cmd_stream_decoder_pkg.sv
// Shared types, opcodes and decode helpers for the command stream decoder.
// Header layout in word bits [31:0]: op[7:0], id[15:8], len[23:16], rsvd[31:24].
package cmd_stream_decoder_pkg;

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      PAY   = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DRAIN = 3'd4
   } cmd_dec_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BAD_OP  = 2'd1,
      ERR_BAD_LEN = 2'd2,
      ERR_WAIT_TO = 2'd3
   } cmd_err_e;

   typedef struct packed {
      logic [7:0] rsvd;
      logic [7:0] len;
      logic [7:0] id;
      logic [7:0] op;
   } cmd_op_s;

   localparam logic [7:0] OP_FETCH     = 8'hF0;
   localparam logic [7:0] OP_DISP      = 8'hF1;
   localparam logic [7:0] OP_TILE      = 8'hF2;
   localparam logic [7:0] OP_WAIT_DISP = 8'hF3;
   localparam logic [7:0] OP_WAIT_TILE = 8'hF4;
   localparam logic [7:0] OP_READOUT   = 8'hF5;

   // Expected payload length in bytes per opcode.
   localparam logic [7:0] CMD_FETCH_LEN   = 8'd12;
   localparam logic [7:0] CMD_DISP_LEN    = 8'd12;
   localparam logic [7:0] CMD_TILE_LEN    = 8'd12;
   localparam logic [7:0] CMD_WAIT_LEN    = 8'd4;
   localparam logic [7:0] CMD_READOUT_LEN = 8'd4;

   typedef struct packed {
      logic       known;
      logic       is_wait;
      logic [1:0] ch;       // issue channel, or tracker select (0 disp, 1 tile) for waits
      logic [7:0] exp_len;
   } op_info_s;

   function automatic op_info_s op_decode(input logic [7:0] op);
      op_info_s info;
      info = '{known: 1'b1, is_wait: 1'b0, ch: 2'd0, exp_len: CMD_FETCH_LEN};
      case (op)
         OP_FETCH: ;
         OP_DISP: begin
            info.ch      = 2'd1;
            info.exp_len = CMD_DISP_LEN;
         end
         OP_TILE: begin
            info.ch      = 2'd2;
            info.exp_len = CMD_TILE_LEN;
         end
         OP_WAIT_DISP: begin
            info.is_wait = 1'b1;
            info.ch      = 2'd0;
            info.exp_len = CMD_WAIT_LEN;
         end
         OP_WAIT_TILE: begin
            info.is_wait = 1'b1;
            info.ch      = 2'd1;
            info.exp_len = CMD_WAIT_LEN;
         end
         OP_READOUT: begin
            info.ch      = 2'd3;
            info.exp_len = CMD_READOUT_LEN;
         end
         default: info.known = 1'b0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/cmd_stream_decoder_tracker.sv
// Completion tracker: remembers the last reported ID and whether any report
// has been seen, and compares it against the ID a wait command is looking for.
module cmd_done_tracker #(
   parameter int ID_W = 8
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            done_v_i,
   input  logic [ID_W-1:0] done_id_i,
   input  logic [ID_W-1:0] wait_id_i,
   output logic            match_o
);

   logic            seen_reg;
   logic [ID_W-1:0] last_id_reg;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         seen_reg    <= 1'b0;
         last_id_reg <= '0;
      end else if (done_v_i) begin
         seen_reg    <= 1'b1;
         last_id_reg <= done_id_i;
      end
   end

   assign match_o = seen_reg && (last_id_reg == wait_id_i);

endmodule

// File: rtl/cmd_stream_decoder.sv
// Command stream decoder: pops header + payload words, validates them, issues
// on a per-engine valid/ready channel, resolves waits and reports sticky errors.
module cmd_stream_decoder
   import cmd_stream_decoder_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int MAX_PAY_W = 3,
   parameter int ID_W      = 8,
   parameter int NUM_CH    = 4,
   parameter int WAIT_TO_W = 20,
   parameter int CNT_W     = 32
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        cmd_v_i,
   input  logic [WORD_W-1:0]           cmd_data_i,
   output logic                        cmd_yumi_o,
   output logic [NUM_CH-1:0]           ch_v_o,
   input  logic [NUM_CH-1:0]           ch_ready_i,
   output logic [MAX_PAY_W*WORD_W-1:0] ch_payload_o,
   output logic [ID_W-1:0]             ch_id_o,
   input  logic                        disp_done_v_i,
   input  logic [ID_W-1:0]             disp_done_id_i,
   input  logic                        tile_done_v_i,
   input  logic [ID_W-1:0]             tile_done_id_i,
   input  logic [WAIT_TO_W-1:0]        wait_timeout_i,
   input  logic                        err_clr_i,
   output logic                        err_v_o,
   output logic [1:0]                  err_code_o,
   output logic                        busy_o,
   output logic [CNT_W-1:0]            issued_cnt_o
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   cmd_dec_state_e       state_reg, state_next;
   op_info_s             hdr_info;
   logic [5:0]           hdr_nwords;
   logic [5:0]           nwords_reg;
   logic [5:0]           wcnt_reg;
   logic [CH_W-1:0]      ch_reg;
   logic                 is_wait_reg;
   logic                 wait_sel_reg;
   logic [ID_W-1:0]      id_reg;
   logic [WAIT_TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic [CNT_W-1:0]     issued_cnt_reg;
   logic                 err_v_reg;
   cmd_err_e             err_code_reg;
   logic                 err_set;
   cmd_err_e             err_new;
   logic                 hdr_take;
   logic                 last_word;
   logic                 issue_fire;
   logic                 to_hit;
   logic                 disp_match, tile_match, wait_match;
   logic [ID_W-1:0]      wait_id;

   assign hdr_info   = op_decode(cmd_data_i[7:0]);
   assign hdr_nwords = cmd_data_i[23:18];
   assign hdr_take   = (state_reg == HDR) && cmd_v_i;
   assign last_word  = cmd_v_i && ((wcnt_reg + 6'd1) == nwords_reg);
   assign issue_fire = (state_reg == ISSUE) && ch_ready_i[ch_reg];
   assign wait_id    = ch_payload_o[ID_W-1:0];
   assign wait_match = wait_sel_reg ? tile_match : disp_match;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_reg <= HDR;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      err_set     = 1'b0;
      err_new     = ERR_NONE;
      to_cnt_next = to_cnt_reg + WAIT_TO_W'(1);
      to_hit      = (wait_timeout_i != '0) && (to_cnt_next == wait_timeout_i);
      case (state_reg)
         HDR: if (cmd_v_i) begin
            if (!hdr_info.known) begin
               err_set    = 1'b1;
               err_new    = ERR_BAD_OP;
               state_next = (hdr_nwords == 6'd0) ? HDR : DRAIN;
            end else if (cmd_data_i[23:16] != hdr_info.exp_len) begin
               // Expected lengths are word multiples, so this also catches ragged lengths.
               err_set    = 1'b1;
               err_new    = ERR_BAD_LEN;
               state_next = (hdr_nwords == 6'd0) ? HDR : DRAIN;
            end else if (hdr_nwords == 6'd0) begin
               state_next = hdr_info.is_wait ? WAIT : ISSUE;
            end else begin
               state_next = PAY;
            end
         end
         PAY:   if (last_word) state_next = is_wait_reg ? WAIT : ISSUE;
         ISSUE: if (issue_fire) state_next = HDR;
         WAIT: begin
            if (wait_match) begin
               state_next = HDR;
            end else if (to_hit) begin
               err_set    = 1'b1;
               err_new    = ERR_WAIT_TO;
               state_next = HDR;
            end
         end
         DRAIN: if (last_word) state_next = HDR;
         default: state_next = HDR;
      endcase
   end

   always_comb begin
      cmd_yumi_o = 1'b0;
      busy_o     = 1'b1;
      case (state_reg)
         HDR: begin
            cmd_yumi_o = cmd_v_i;
            busy_o     = 1'b0;
         end
         PAY, DRAIN: cmd_yumi_o = cmd_v_i;
         default: ;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch_v
         assign ch_v_o[gi] = (state_reg == ISSUE) && (ch_reg == CH_W'(gi));
      end

      // Slots are cleared on every header so words beyond the payload read as zero.
      for (gi = 0; gi < MAX_PAY_W; gi++) begin : g_slot
         logic [WORD_W-1:0] slot_reg;
         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)
               slot_reg <= '0;
            else if (hdr_take)
               slot_reg <= '0;
            else if ((state_reg == PAY) && cmd_v_i && (wcnt_reg == 6'(gi)))
               slot_reg <= cmd_data_i;
         end
         assign ch_payload_o[gi*WORD_W +: WORD_W] = slot_reg;
      end
   endgenerate

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         nwords_reg     <= '0;
         wcnt_reg       <= '0;
         ch_reg         <= '0;
         is_wait_reg    <= 1'b0;
         wait_sel_reg   <= 1'b0;
         id_reg         <= '0;
         to_cnt_reg     <= '0;
         issued_cnt_reg <= '0;
         err_v_reg      <= 1'b0;
         err_code_reg   <= ERR_NONE;
      end else begin
         if (hdr_take) begin
            nwords_reg   <= hdr_nwords;
            wcnt_reg     <= '0;
            ch_reg       <= CH_W'(hdr_info.ch);
            is_wait_reg  <= hdr_info.is_wait;
            wait_sel_reg <= hdr_info.ch[0];
            id_reg       <= ID_W'(cmd_data_i[15:8]);
         end else if (((state_reg == PAY) || (state_reg == DRAIN)) && cmd_v_i) begin
            wcnt_reg <= wcnt_reg + 6'd1;
         end
         to_cnt_reg <= (state_reg == WAIT) ? to_cnt_next : '0;
         if (issue_fire) issued_cnt_reg <= issued_cnt_reg + CNT_W'(1);
         if (err_set) begin
            err_v_reg    <= 1'b1;
            err_code_reg <= err_new;
         end else if (err_clr_i) begin
            err_v_reg    <= 1'b0;
            err_code_reg <= ERR_NONE;
         end
      end
   end

   cmd_done_tracker #(.ID_W(ID_W)) u_disp_tracker (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .done_v_i  (disp_done_v_i),
      .done_id_i (disp_done_id_i),
      .wait_id_i (wait_id),
      .match_o   (disp_match)
   );

   cmd_done_tracker #(.ID_W(ID_W)) u_tile_tracker (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .done_v_i  (tile_done_v_i),
      .done_id_i (tile_done_id_i),
      .wait_id_i (wait_id),
      .match_o   (tile_match)
   );

   assign ch_id_o      = id_reg;
   assign issued_cnt_o = issued_cnt_reg;
   assign err_v_o      = err_v_reg;
   assign err_code_o   = err_code_reg;

endmodule

// File: tb/tb_cmd_stream_decoder.sv
// Directed bench for cmd_stream_decoder: issue, backpressure, waits, errors,
// timeout and mid-command reset, each scenario with hand-computed expectations.
module tb_cmd_stream_decoder;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        cmd_v;
   logic [31:0] cmd_data;
   logic        cmd_yumi;
   logic [3:0]  ch_v;
   logic [3:0]  ch_ready;
   logic [95:0] ch_payload;
   logic [7:0]  ch_id;
   logic        disp_done_v, tile_done_v;
   logic [7:0]  disp_done_id, tile_done_id;
   logic [19:0] wait_timeout;
   logic        err_clr;
   logic        err_v;
   logic [1:0]  err_code;
   logic        busy;
   logic [31:0] issued_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cmd_stream_decoder dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .cmd_v_i        (cmd_v),
      .cmd_data_i     (cmd_data),
      .cmd_yumi_o     (cmd_yumi),
      .ch_v_o         (ch_v),
      .ch_ready_i     (ch_ready),
      .ch_payload_o   (ch_payload),
      .ch_id_o        (ch_id),
      .disp_done_v_i  (disp_done_v),
      .disp_done_id_i (disp_done_id),
      .tile_done_v_i  (tile_done_v),
      .tile_done_id_i (tile_done_id),
      .wait_timeout_i (wait_timeout),
      .err_clr_i      (err_clr),
      .err_v_o        (err_v),
      .err_code_o     (err_code),
      .busy_o         (busy),
      .issued_cnt_o   (issued_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] w);
      cmd_v    = 1'b1;
      cmd_data = w;
      tick();
      cmd_v    = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      tick();
      checks++; if (ch_v !== 4'b0) begin errors++; $display("FAIL reset_ch_v got=%b exp=0000", ch_v); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (ch_payload !== 96'h0) begin errors++; $display("FAIL reset_payload got=%h exp=0", ch_payload); end
      checks++; if (issued_cnt !== 32'd0 || err_v !== 1'b0 || err_code !== 2'd0 || ch_id !== 8'd0)
         begin errors++; $display("FAIL reset_regs cnt=%0d err_v=%b code=%0d id=%h exp all 0", issued_cnt, err_v, err_code, ch_id); end
      tick();
      reset_i = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      cmd_v = 1'b1; cmd_data = 32'h000C_05F0; #1;
      checks++; if (cmd_yumi !== 1'b1) begin errors++; $display("FAIL fetch_hdr_yumi got=%b exp=1", cmd_yumi); end
      tick();
      put(32'h0000_1000);
      put(32'h0000_0040);
      cmd_v = 1'b1; cmd_data = 32'h0000_0001; #1;
      checks++; if (ch_v !== 4'b0000) begin errors++; $display("FAIL fetch_early_v got=%b exp=0000", ch_v); end
      tick();
      cmd_v = 1'b1; cmd_data = 32'h0000_0000; #1;
      checks++; if (ch_v !== 4'b0001) begin errors++; $display("FAIL fetch_ch_v got=%b exp=0001", ch_v); end
      checks++; if (ch_payload !== 96'h00000001_00000040_00001000) begin errors++; $display("FAIL fetch_payload got=%h exp=00000001_00000040_00001000", ch_payload); end
      checks++; if (ch_id !== 8'h05) begin errors++; $display("FAIL fetch_id got=%h exp=05", ch_id); end
      checks++; if (cmd_yumi !== 1'b0) begin errors++; $display("FAIL fetch_issue_yumi got=%b exp=0", cmd_yumi); end
      cmd_v = 1'b0;
      ch_ready = 4'b0001;
      tick();
      ch_ready = 4'b0000;
      checks++; if (issued_cnt !== 32'd1) begin errors++; $display("FAIL fetch_cnt got=%0d exp=1", issued_cnt); end
      checks++; if (busy !== 1'b0 || ch_v !== 4'b0) begin errors++; $display("FAIL fetch_done busy=%b ch_v=%b exp 0/0000", busy, ch_v); end
      $display("fetch id=05 issued on ch0, issued_cnt=%0d", issued_cnt);
   endtask

   task automatic test_backpressure();
      put(32'h000C_09F2);
      put(32'h0000_000A);
      put(32'h0000_000B);
      put(32'h0000_000C);
      for (int i = 0; i < 5; i++) begin
         cmd_v = 1'b1; cmd_data = 32'hDEAD_BEEF; #1;
         checks++; if (ch_v !== 4'b0100) begin errors++; $display("FAIL bp_ch_v[%0d] got=%b exp=0100", i, ch_v); end
         checks++; if (ch_payload !== 96'h0000000C_0000000B_0000000A) begin errors++; $display("FAIL bp_payload[%0d] got=%h exp=0000000C_0000000B_0000000A", i, ch_payload); end
         checks++; if (cmd_yumi !== 1'b0) begin errors++; $display("FAIL bp_yumi[%0d] got=%b exp=0", i, cmd_yumi); end
         tick();
      end
      cmd_v = 1'b0;
      checks++; if (issued_cnt !== 32'd1) begin errors++; $display("FAIL bp_cnt_held got=%0d exp=1", issued_cnt); end
      ch_ready = 4'b0100;
      tick();
      ch_ready = 4'b0000;
      checks++; if (issued_cnt !== 32'd2 || ch_v !== 4'b0) begin errors++; $display("FAIL bp_release cnt=%0d ch_v=%b exp 2/0000", issued_cnt, ch_v); end
      $display("tile id=09 issued on ch2 after 5 stall cycles, issued_cnt=%0d", issued_cnt);
   endtask

   task automatic test_wait();
      disp_done_v = 1'b1; disp_done_id = 8'h07;
      tick();
      disp_done_v = 1'b0;
      put(32'h0004_11F3);
      put(32'h0000_0007);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_pre_busy got=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_pre_exit got=%b exp=0", busy); end
      $display("wait_disp id=07 satisfied by earlier report");

      disp_done_v = 1'b1; disp_done_id = 8'h06;
      tick();
      disp_done_v = 1'b0;
      put(32'h0004_12F3);
      put(32'h0000_0007);
      for (int i = 0; i < 4; i++) begin
         cmd_v = 1'b1; cmd_data = 32'h0004_00F5; #1;
         checks++; if (busy !== 1'b1 || cmd_yumi !== 1'b0) begin errors++; $display("FAIL wait_hold[%0d] busy=%b yumi=%b exp 1/0", i, busy, cmd_yumi); end
         tick();
      end
      cmd_v = 1'b0;
      disp_done_v = 1'b1; disp_done_id = 8'h07;
      tick();
      disp_done_v = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_late_busy got=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_late_exit got=%b exp=0", busy); end
      $display("wait_disp id=07 released by late report");

      put(32'h0004_13F4);
      tile_done_v = 1'b1; tile_done_id = 8'h33;
      put(32'h0000_0033);
      tile_done_v = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_same_busy got=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0 || err_v !== 1'b0) begin errors++; $display("FAIL wait_same_exit busy=%b err_v=%b exp 0/0", busy, err_v); end
      $display("wait_tile id=33 satisfied by same-cycle report");
   endtask

   task automatic test_bad_op();
      put(32'h0008_01AA);
      checks++; if (err_v !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL badop_err v=%b code=%0d exp 1/1", err_v, err_code); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL badop_drain_busy got=%b exp=1", busy); end
      cmd_v = 1'b1; cmd_data = 32'h1111_1111; #1;
      checks++; if (cmd_yumi !== 1'b1) begin errors++; $display("FAIL badop_drain_yumi got=%b exp=1", cmd_yumi); end
      tick();
      put(32'h2222_2222);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badop_drain_done got=%b exp=0", busy); end
      put(32'h0004_22F5);
      put(32'h0000_CAFE);
      checks++; if (ch_v !== 4'b1000 || ch_id !== 8'h22) begin errors++; $display("FAIL readout_issue ch_v=%b id=%h exp 1000/22", ch_v, ch_id); end
      checks++; if (ch_payload !== 96'h00000000_00000000_0000CAFE) begin errors++; $display("FAIL readout_payload got=%h exp=00000000_00000000_0000CAFE", ch_payload); end
      ch_ready = 4'b1000;
      tick();
      ch_ready = 4'b0000;
      checks++; if (issued_cnt !== 32'd3) begin errors++; $display("FAIL readout_cnt got=%0d exp=3", issued_cnt); end
      $display("unknown op AA drained 2 words, readout id=22 issued on ch3");
   endtask

   task automatic test_bad_len();
      put(32'h0008_05F0);
      checks++; if (err_v !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL badlen_err v=%b code=%0d exp 1/2", err_v, err_code); end
      put(32'h3333_3333);
      put(32'h4444_4444);
      checks++; if (busy !== 1'b0 || issued_cnt !== 32'd3) begin errors++; $display("FAIL badlen_drop busy=%b cnt=%0d exp 0/3", busy, issued_cnt); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++; if (err_v !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL err_clear v=%b code=%0d exp 0/0", err_v, err_code); end
      err_clr = 1'b1;
      put(32'h0000_01AA);
      err_clr = 1'b0;
      checks++; if (err_v !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL err_vs_clr v=%b code=%0d busy=%b exp 1/1/0", err_v, err_code, busy); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      $display("fetch len 8 rejected, error cleared");
   endtask

   task automatic test_timeout();
      wait_timeout = 20'd10;
      put(32'h0004_44F4);
      put(32'h0000_0055);
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++; if (busy !== 1'b1 || err_v !== 1'b0) begin errors++; $display("FAIL to_hold[%0d] busy=%b err_v=%b exp 1/0", i, busy, err_v); end
      end
      tick();
      checks++; if (busy !== 1'b0 || err_v !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL to_fire busy=%b err_v=%b code=%0d exp 0/1/3", busy, err_v, err_code); end
      wait_timeout = 20'd0;
      $display("wait_tile id=55 timed out after 10 cycles");
   endtask

   task automatic test_reset_mid();
      put(32'h000C_05F0);
      put(32'h0000_1234);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre busy=%b exp=1", busy); end
      reset_i = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || ch_v !== 4'b0 || cmd_yumi !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl busy=%b ch_v=%b yumi=%b exp 0", busy, ch_v, cmd_yumi); end
      checks++; if (ch_payload !== 96'h0 || ch_id !== 8'h0 || issued_cnt !== 32'd0 || err_v !== 1'b0 || err_code !== 2'd0)
         begin errors++; $display("FAIL rst_mid_regs pay=%h id=%h cnt=%0d err_v=%b code=%0d exp 0", ch_payload, ch_id, issued_cnt, err_v, err_code); end
      tick();
      reset_i = 1'b0;
      tick();
      put(32'h0004_66F5);
      put(32'h0000_0077);
      checks++; if (ch_v !== 4'b1000 || ch_id !== 8'h66) begin errors++; $display("FAIL rst_recover ch_v=%b id=%h exp 1000/66", ch_v, ch_id); end
      ch_ready = 4'b1000;
      tick();
      ch_ready = 4'b0000;
      checks++; if (issued_cnt !== 32'd1) begin errors++; $display("FAIL rst_recover_cnt got=%0d exp=1", issued_cnt); end
      $display("reset during payload aborted fetch, readout id=66 issued after");
   endtask

   initial begin
      reset_i = 1'b1;
      cmd_v = 1'b0; cmd_data = 32'h0;
      ch_ready = 4'b0;
      disp_done_v = 1'b0; disp_done_id = 8'h0;
      tile_done_v = 1'b0; tile_done_id = 8'h0;
      wait_timeout = 20'd0;
      err_clr = 1'b0;
      test_reset();
      test_fetch();
      test_backpressure();
      test_wait();
      test_bad_op();
      test_bad_len();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

endmodule
